// File: rtl/pipe_skid_reg_pkg.sv
// Shared definitions for the two-entry skid pipeline register:
// state encoding, default parameters and state decode helpers.
package pipe_skid_reg_pkg;

  // Occupancy states; the encoding matches the entry count directly.
  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_FULL  = 2'd2
  } state_t;

  localparam int           DEFAULT_WIDTH   = 32;
  localparam logic [255:0] DEFAULT_CLR_VAL = 256'd0;

  // Number of entries held in a given state.
  function automatic logic [1:0] state_count(input state_t s);
    logic [1:0] c;
    case (s)
      ST_EMPTY: c = 2'd0;
      ST_ONE:   c = 2'd1;
      ST_FULL:  c = 2'd2;
      default:  c = 2'd0;
    endcase
    return c;
  endfunction

  // The stage can take a new entry unless both slots are occupied.
  function automatic logic state_ready(input state_t s);
    logic r;
    case (s)
      ST_EMPTY: r = 1'b1;
      ST_ONE:   r = 1'b1;
      ST_FULL:  r = 1'b0;
      default:  r = 1'b1;
    endcase
    return r;
  endfunction

  // The head slot holds a valid entry whenever the stage is non-empty.
  function automatic logic state_valid(input state_t s);
    logic v;
    case (s)
      ST_EMPTY: v = 1'b0;
      ST_ONE:   v = 1'b1;
      ST_FULL:  v = 1'b1;
      default:  v = 1'b0;
    endcase
    return v;
  endfunction

endpackage

// File: rtl/pipe_skid_reg_data_reg_w.sv
// WIDTH-bit storage register with load enable, synchronous clear to
// CLR_VAL and asynchronous active-low reset to CLR_VAL.
module data_reg_w
  import pipe_skid_reg_pkg::*;
#(
  parameter int               WIDTH   = DEFAULT_WIDTH,
  parameter logic [WIDTH-1:0] CLR_VAL = DEFAULT_CLR_VAL[WIDTH-1:0]
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clr,
  input  logic             en,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] q_r;

  // Storage: clear has priority over load; otherwise hold.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      q_r <= CLR_VAL;
    end else if (clr) begin
      q_r <= CLR_VAL;
    end else if (en) begin
      q_r <= d;
    end else begin
      q_r <= q_r;
    end
  end

  assign q = q_r;

endmodule

// File: rtl/pipe_skid_reg.sv
// Two-entry skid pipeline register. The main slot always drives out_data;
// the skid slot absorbs one extra entry so in_ready can be a registered
// function of state only, cutting the combinational ready path.
module pipe_skid_reg
  import pipe_skid_reg_pkg::*;
#(
  parameter int               WIDTH   = DEFAULT_WIDTH,
  parameter logic [WIDTH-1:0] CLR_VAL = DEFAULT_CLR_VAL[WIDTH-1:0]
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic [1:0]       count
);

  state_t           state_r;
  state_t           state_next_s;
  logic             in_ready_r;
  logic             out_valid_r;
  logic [1:0]       count_r;

  logic             in_xfer_s;
  logic             out_xfer_s;
  logic             main_en_s;
  logic             skid_en_s;
  logic             clr_s;
  logic [WIDTH-1:0] main_d_s;
  logic [WIDTH-1:0] main_q_s;
  logic [WIDTH-1:0] skid_q_s;

  assign in_xfer_s  = in_valid && in_ready_r;
  assign out_xfer_s = out_valid_r && out_ready;

  // Next-state and slot-load decode; flush overrides every transfer.
  always_comb begin
    state_next_s = state_r;
    main_en_s    = 1'b0;
    skid_en_s    = 1'b0;
    main_d_s     = in_data;
    clr_s        = 1'b0;
    if (flush) begin
      state_next_s = ST_EMPTY;
      clr_s        = 1'b1;
    end else begin
      case (state_r)
        ST_EMPTY: begin
          if (in_xfer_s) begin
            main_en_s    = 1'b1;
            state_next_s = ST_ONE;
          end else begin
            state_next_s = ST_EMPTY;
          end
        end
        ST_ONE: begin
          if (in_xfer_s && out_xfer_s) begin
            main_en_s    = 1'b1;
            state_next_s = ST_ONE;
          end else if (in_xfer_s) begin
            skid_en_s    = 1'b1;
            state_next_s = ST_FULL;
          end else if (out_xfer_s) begin
            state_next_s = ST_EMPTY;
          end else begin
            state_next_s = ST_ONE;
          end
        end
        ST_FULL: begin
          if (out_xfer_s) begin
            main_d_s     = skid_q_s;
            main_en_s    = 1'b1;
            state_next_s = ST_ONE;
          end else begin
            state_next_s = ST_FULL;
          end
        end
        default: begin
          state_next_s = ST_EMPTY;
        end
      endcase
    end
  end

  // State register with handshake flags and count registered alongside it.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_r     <= ST_EMPTY;
      in_ready_r  <= 1'b1;
      out_valid_r <= 1'b0;
      count_r     <= 2'd0;
    end else begin
      state_r     <= state_next_s;
      in_ready_r  <= state_ready(state_next_s);
      out_valid_r <= state_valid(state_next_s);
      count_r     <= state_count(state_next_s);
    end
  end

  data_reg_w #(.WIDTH(WIDTH), .CLR_VAL(CLR_VAL)) u_main (
    .clk   (clk),
    .reset (reset),
    .clr   (clr_s),
    .en    (main_en_s),
    .d     (main_d_s),
    .q     (main_q_s)
  );

  data_reg_w #(.WIDTH(WIDTH), .CLR_VAL(CLR_VAL)) u_skid (
    .clk   (clk),
    .reset (reset),
    .clr   (clr_s),
    .en    (skid_en_s),
    .d     (in_data),
    .q     (skid_q_s)
  );

  assign in_ready  = in_ready_r;
  assign out_valid = out_valid_r;
  assign count     = count_r;
  assign out_data  = main_q_s;

endmodule

// File: tb/tb_pipe_skid_reg.sv
// Bench for pipe_skid_reg: directed scenarios on a 32-bit instance and a
// long randomized run on 8-bit and 64-bit instances checked against a
// queue-based reference model.
module tb_pipe_skid_reg;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        flush = 1'b0;
  logic        in_valid = 1'b0;
  logic        out_ready = 1'b0;
  logic [31:0] d32 = 32'd0;
  logic [7:0]  d8 = 8'd0;
  logic [63:0] d64 = 64'd0;

  logic        ir32, ov32, ir8, ov8, ir64, ov64;
  logic [1:0]  cnt32, cnt8, cnt64;
  logic [31:0] q32;
  logic [7:0]  q8;
  logic [63:0] q64;

  int total = 0;
  int bad = 0;

  always #5 clk = ~clk;

  pipe_skid_reg #(.WIDTH(32)) dut32 (
    .clk(clk), .reset(reset), .flush(flush), .in_valid(in_valid), .in_ready(ir32),
    .in_data(d32), .out_valid(ov32), .out_ready(out_ready), .out_data(q32), .count(cnt32)
  );
  pipe_skid_reg #(.WIDTH(8)) dut8 (
    .clk(clk), .reset(reset), .flush(flush), .in_valid(in_valid), .in_ready(ir8),
    .in_data(d8), .out_valid(ov8), .out_ready(out_ready), .out_data(q8), .count(cnt8)
  );
  pipe_skid_reg #(.WIDTH(64)) dut64 (
    .clk(clk), .reset(reset), .flush(flush), .in_valid(in_valid), .in_ready(ir64),
    .in_data(d64), .out_valid(ov64), .out_ready(out_ready), .out_data(q64), .count(cnt64)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One clock edge, then settle past it before sampling.
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic chk32(input string tag, input logic v, input logic r,
                       input logic [1:0] c, input logic [31:0] d);
    chk({tag, ".out_valid"}, {63'd0, ov32}, {63'd0, v});
    chk({tag, ".in_ready"},  {63'd0, ir32}, {63'd0, r});
    chk({tag, ".count"},     {62'd0, cnt32}, {62'd0, c});
    chk({tag, ".out_data"},  {32'd0, q32}, {32'd0, d});
  endtask

  // Reference model: the stage is a FIFO of at most two entries; when it
  // is empty, out_data shows the last head value (or 0 after reset/flush).
  logic [63:0] mq[$];
  logic [63:0] last_head;

  initial begin
    int sz;
    bit pop_ok;
    bit push_ok;
    logic [63:0] exp64;
    logic [7:0]  exp8;

    // ---- asynchronous reset state ----
    #3 reset = 1'b0;
    #1 chk32("reset", 1'b0, 1'b1, 2'd0, 32'h0);
    @(negedge clk); reset = 1'b1;

    // ---- streaming: one value per cycle, count stays 1 ----
    in_valid = 1'b1; out_ready = 1'b1; d32 = 32'd1;
    cyc();
    chk32("stream1", 1'b1, 1'b1, 2'd1, 32'd1);
    for (int k = 2; k <= 6; k++) begin
      d32 = k;
      cyc();
      chk32("stream", 1'b1, 1'b1, 2'd1, k);
    end
    in_valid = 1'b0;
    cyc();
    chk32("stream_drain", 1'b0, 1'b1, 2'd0, 32'd6);

    // ---- fill to FULL, stall, then drain in order ----
    out_ready = 1'b0; in_valid = 1'b1; d32 = 32'hA;
    cyc();
    chk32("fillA", 1'b1, 1'b1, 2'd1, 32'hA);
    d32 = 32'hB;
    cyc();
    chk32("fillB", 1'b1, 1'b0, 2'd2, 32'hA);
    in_valid = 1'b1; d32 = 32'hE;
    cyc();
    chk32("stall_full", 1'b1, 1'b0, 2'd2, 32'hA);
    in_valid = 1'b0; out_ready = 1'b1;
    cyc();
    chk32("drainA", 1'b1, 1'b1, 2'd1, 32'hB);
    cyc();
    chk32("drainB", 1'b0, 1'b1, 2'd0, 32'hB);

    // ---- flush while FULL drops the offered entry ----
    out_ready = 1'b0; in_valid = 1'b1; d32 = 32'hA;
    cyc();
    d32 = 32'hB;
    cyc();
    chk32("pre_flush", 1'b1, 1'b0, 2'd2, 32'hA);
    flush = 1'b1; d32 = 32'hC;
    cyc();
    chk32("flush", 1'b0, 1'b1, 2'd0, 32'h0);
    flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    cyc();
    chk32("post_flush", 1'b0, 1'b1, 2'd0, 32'h0);

    // ---- async reset mid-FULL ----
    out_ready = 1'b0; in_valid = 1'b1; d32 = 32'h11;
    cyc();
    d32 = 32'h22;
    cyc();
    chk32("pre_reset", 1'b1, 1'b0, 2'd2, 32'h11);
    in_valid = 1'b0;
    #2 reset = 1'b0;
    #1 chk32("mid_reset", 1'b0, 1'b1, 2'd0, 32'h0);
    @(negedge clk); reset = 1'b1;
    in_valid = 1'b1; d32 = 32'h33;
    cyc();
    chk32("after_reset", 1'b1, 1'b1, 2'd1, 32'h33);
    in_valid = 1'b0; out_ready = 1'b1;
    cyc();
    chk32("after_reset_drain", 1'b0, 1'b1, 2'd0, 32'h33);

    // ---- randomized run on the 8-bit and 64-bit instances ----
    reset = 1'b0;
    @(negedge clk); reset = 1'b1;
    mq.delete();
    last_head = 64'd0;
    for (int n = 0; n < 10000; n++) begin
      // bias phases so both FULL back-pressure and draining occur often
      if ((n / 500) % 2 == 0) begin
        in_valid  = ($urandom_range(0, 3) != 0);
        out_ready = ($urandom_range(0, 3) == 0);
      end else begin
        in_valid  = ($urandom_range(0, 3) == 0);
        out_ready = ($urandom_range(0, 3) != 0);
      end
      flush = ($urandom_range(0, 99) == 0);
      d64 = {$urandom, $urandom};
      d8  = d64[7:0];
      @(posedge clk);
      sz = mq.size();
      if (flush) begin
        mq.delete();
        last_head = 64'd0;
      end else begin
        pop_ok  = (sz > 0) && out_ready;
        push_ok = in_valid && (sz < 2);
        if (pop_ok) void'(mq.pop_front());
        if (push_ok) mq.push_back(d64);
        if (mq.size() > 0) last_head = mq[0];
      end
      #1;
      exp64 = last_head;
      exp8  = exp64[7:0];
      chk("rnd64.count",     {62'd0, cnt64}, mq.size());
      chk("rnd64.in_ready",  {63'd0, ir64},  {63'd0, (mq.size() < 2)});
      chk("rnd64.out_valid", {63'd0, ov64},  {63'd0, (mq.size() > 0)});
      chk("rnd64.out_data",  q64, exp64);
      chk("rnd8.count",      {62'd0, cnt8},  mq.size());
      chk("rnd8.in_ready",   {63'd0, ir8},   {63'd0, (mq.size() < 2)});
      chk("rnd8.out_valid",  {63'd0, ov8},   {63'd0, (mq.size() > 0)});
      chk("rnd8.out_data",   {56'd0, q8},    {56'd0, exp8});
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/pipe_skid_reg.md
PIPE_SKID_REG -- requirements
Module: pipe_skid_reg

Interface
REQ-001 SHALL have parameter WIDTH, default 32, data width in bits (1..256).
REQ-002 SHALL have parameter CLR_VAL, default all-zero WIDTH-bit value, value loaded into data storage on reset/flush.
REQ-003 SHALL have port clk  input  1  single clock, all state on rising edge.
REQ-004 SHALL have port reset  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port flush  input  1  synchronous clear of stage contents (pipeline flush on branch/exception).
REQ-006 SHALL have port in_valid  input  1  producer offers in_data.
REQ-007 SHALL have port in_ready  output  1  stage can accept; registered, depends on state only.
REQ-008 SHALL have port in_data  input  WIDTH  payload from producer.
REQ-009 SHALL have port out_valid  output  1  out_data holds a valid entry.
REQ-010 SHALL have port out_ready  input  1  consumer accepts out_data.
REQ-011 SHALL have port out_data  output  WIDTH  head entry payload.
REQ-012 SHALL have port count  output  2  entries held (0,1,2).

Function
REQ-013 SHALL hold two entries: main (drives out_data) and skid; states EMPTY, ONE, FULL.
REQ-014 Input transfer SHALL occur when in_valid && in_ready; output transfer when out_valid && out_ready.
REQ-015 in_ready SHALL be 1 in EMPTY and ONE, 0 in FULL; out_valid SHALL be 1 in ONE and FULL.
REQ-016 EMPTY + input transfer SHALL load main<=in_data, go to ONE (accept-to-out_valid latency 1 cycle).
REQ-017 ONE + input and output transfer SHALL load main<=in_data, stay ONE (throughput 1/cycle).
REQ-018 ONE + input transfer only SHALL load skid<=in_data, go to FULL.
REQ-019 ONE + output transfer only SHALL go to EMPTY, main unchanged.
REQ-020 FULL + output transfer SHALL load main<=skid, go to ONE; no input transfer possible in FULL.
REQ-021 No transfer SHALL leave state and data unchanged (stall holds data stable).
REQ-022 flush SHALL override all transfers that cycle: state<=EMPTY, main and skid<=CLR_VAL, in_data that cycle dropped even if in_valid=1.
REQ-023 out_data SHALL always equal main register, including in EMPTY (last value or CLR_VAL).
REQ-024 count SHALL equal 0/1/2 for EMPTY/ONE/FULL, registered with state.
REQ-025 Data order SHALL be strictly FIFO; no entry lost or duplicated outside flush/reset.

Reset
REQ-026 reset low SHALL asynchronously force state EMPTY, main and skid CLR_VAL, in_ready 1, out_valid 0, count 0.
REQ-027 reset asserted mid-transfer SHALL discard all entries; first rising edge after deassertion behaves as EMPTY.

Structure
REQ-028 Shared package SHALL hold state encoding (EMPTY=2'd0, ONE=2'd1, FULL=2'd2) and default CLR_VAL constant.
REQ-029 SHALL instantiate sub-module data_reg_w twice (main, skid): WIDTH-bit register with enable, sync clear to CLR_VAL, async active-low reset.
REQ-030 Control SHALL be one state register plus next-state logic; no combinational path in_valid->in_ready or out_ready->out_valid.

Verification
REQ-031 Reset low mid-FULL with main=0x11, skid=0x22 -> immediately out_valid=0, count=0, in_ready=1, out_data=CLR_VAL.
REQ-032 out_ready=1, in_valid=1 every cycle, data 1,2,3,... -> out_data=1 one cycle after first accept, then one new value per cycle, count stays 1.
REQ-033 WIDTH=32: accept 0xA, 0xB with out_ready=0 -> count=2, in_ready=0, out_data=0xA; raise out_ready -> 0xA then 0xB, count 1 then 0.
REQ-034 FULL with 0xA,0xB, flush=1 with in_valid=1, in_data=0xC -> next cycle count=0, out_valid=0, out_data=CLR_VAL; 0xC never appears.
REQ-035 Random in_valid/out_ready 10k cycles, WIDTH=8 and WIDTH=64 -> scoreboard order matches, no loss/duplication, in_ready=0 exactly when count=2.
